// File: rtl/data_split.sv
// data_split: width-reducing gearbox that repacks IN_W-bit words into OUT_W-bit words, MSB-first, contiguous stream.
// Latency: the first output word is valid the cycle after the first accepted input word (IN_W >= OUT_W).
// Backpressure: rdy_src drops when the bit buffer cannot take a whole input word; data_out is held while rdy_sink=0.
//
// Ports:
//   clk, rst                     rising-edge clock, asynchronous active-high reset
//   data_in, valid_src, rdy_src  source word handshake (data_in[IN_W-1] is first in stream order)
//   data_out, valid_sink, rdy_sink  sink word handshake (data_out[OUT_W-1] is first in stream order)
//   last_src, last_sink          only with DATA_SPLIT_LAST_EN: end-of-stream marker in, final word marker out
//
// Optional feature macro: DATA_SPLIT_LAST_EN. When defined, an accepted last_src flushes the residual
// bits as a zero-padded final word and blocks the source until that word has been taken.
module data_split #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  data_in,
    input  logic             valid_src,
    output logic             rdy_src,
    output logic [OUT_W-1:0] data_out,
    output logic             valid_sink,
    input  logic             rdy_sink
`ifdef DATA_SPLIT_LAST_EN
    ,
    input  logic             last_src,
    output logic             last_sink
`endif
);

    localparam int BUF_W  = IN_W + OUT_W - 1;
    localparam int FILL_W = $clog2(BUF_W + 1);

    localparam logic [FILL_W-1:0] OUT_F  = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_F   = FILL_W'(IN_W);
    localparam logic [FILL_W-1:0] ROOM_F = FILL_W'(BUF_W - IN_W);

    // Valid bits are left-justified: bit_buf[BUF_W-1] is the oldest bit.
    logic [BUF_W-1:0]  bit_buf;
    logic [BUF_W-1:0]  buf_sh;
    logic [BUF_W-1:0]  buf_nx;
    logic [BUF_W-1:0]  word_ext;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_sh;
    logic [FILL_W-1:0] fill_nx;
    logic              has_word;
    logic              space;
    logic              in_fire;
    logic              out_fire;

    assign has_word = (fill >= OUT_F);

    // A word leaving this cycle frees OUT_W bits, so the source may be accepted
    // against the post-shift fill; this rdy_sink->rdy_src path keeps one word per cycle.
    assign space = (fill <= ROOM_F) | (out_fire & has_word & ((fill - OUT_F) <= ROOM_F));

`ifdef DATA_SPLIT_LAST_EN
    logic flush;

    // During a flush, any residual bits form a final word; bits below fill are kept zero,
    // so the padding comes for free from the buffer contents.
    assign valid_sink = has_word | (flush & (|fill));
    assign rdy_src    = ~flush & space;
    assign last_sink  = flush & valid_sink & (fill <= OUT_F);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush <= 1'b0;
        end else if (in_fire & last_src) begin
            flush <= 1'b1;
        end else if (out_fire & last_sink) begin
            flush <= 1'b0;
        end
    end
`else
    assign valid_sink = has_word;
    assign rdy_src    = space;
`endif

    assign in_fire  = valid_src & rdy_src;
    assign out_fire = valid_sink & rdy_sink;
    assign data_out = valid_sink ? bit_buf[BUF_W-1 -: OUT_W] : '0;

    always_comb begin
        word_ext = '0;
        word_ext[BUF_W-1 -: IN_W] = data_in;
    end

    // Shift out first, then append the new word directly below the remaining bits.
    always_comb begin
        fill_sh = fill;
        buf_sh  = bit_buf;
        if (out_fire) begin
            fill_sh = has_word ? (fill - OUT_F) : '0;
            buf_sh  = bit_buf << OUT_W;
        end
        buf_nx  = buf_sh;
        fill_nx = fill_sh;
        if (in_fire) begin
            buf_nx  = buf_sh | (word_ext >> fill_sh);
            fill_nx = fill_sh + IN_F;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_buf <= '0;
            fill    <= '0;
        end else begin
            bit_buf <= buf_nx;
            fill    <= fill_nx;
        end
    end

endmodule

// File: tb/tb_data_split.sv
// tb_data_split: directed-vector and reference-model bench for the data_split gearbox (23 -> 16).
// Latency: n/a (testbench).
// Backpressure: drives random and held-low rdy_sink to exercise sink stalls.
module tb_data_split;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [22:0] data_in = '0;
    logic        valid_src = 1'b0;
    logic        rdy_src;
    logic [15:0] data_out;
    logic        valid_sink;
    logic        rdy_sink = 1'b0;
`ifdef DATA_SPLIT_LAST_EN
    logic        last_src = 1'b0;
    logic        last_sink;
`endif

    data_split #(.IN_W(23), .OUT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .valid_src  (valid_src),
        .rdy_src    (rdy_src),
        .data_out   (data_out),
        .valid_sink (valid_sink),
        .rdy_sink   (rdy_sink)
`ifdef DATA_SPLIT_LAST_EN
        ,
        .last_src   (last_src),
        .last_sink  (last_sink)
`endif
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        r;
        logic        vs;
        logic [22:0] d;
        logic        rs;
        logic        e_rdy;
        logic        e_vld;
        logic [15:0] e_dat;
    } vec_t;

    localparam int NV = 24;
    vec_t vt[NV];

    task automatic set_vec(input int i, input logic r, input logic vs, input logic [22:0] d,
                           input logic rs, input logic e_rdy, input logic e_vld, input logic [15:0] e_dat);
        vt[i].r = r; vt[i].vs = vs; vt[i].d = d; vt[i].rs = rs;
        vt[i].e_rdy = e_rdy; vt[i].e_vld = e_vld; vt[i].e_dat = e_dat;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        valid_src = 1'b0;
        rdy_sink = 1'b0;
`ifdef DATA_SPLIT_LAST_EN
        last_src = 1'b0;
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic exp_q[$];
    logic [15:0] exp_w;

    task automatic pop_word(output logic [15:0] w, output logic ok);
        w = '0;
        ok = (exp_q.size() >= 16);
        if (ok) begin
            for (int b = 15; b >= 0; b--) w[b] = exp_q.pop_front();
        end
    endtask

    task automatic push_word(input logic [22:0] w);
        for (int b = 22; b >= 0; b--) exp_q.push_back(w[b]);
    endtask

    initial begin
        //            r     vs    data         rs    rdy   vld   dout
        set_vec( 0, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b1, 1'b0, 16'h0000); // in reset
        set_vec( 1, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000); // idle
        set_vec( 2, 1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 16'h0000); // fill 0 -> 23
        set_vec( 3, 1'b0, 1'b1, 23'h000000, 1'b1, 1'b1, 1'b1, 16'hFFFF); // 23 -> 30
        set_vec( 4, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, 16'hFE00); // 30 -> 14
        set_vec( 5, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000); // 14 bits wait
        set_vec( 6, 1'b0, 1'b1, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000); // 14 -> 37
        set_vec( 7, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b0, 1'b1, 16'h0000); // 37 -> 21, no room
        set_vec( 8, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, 16'h0000); // 21 -> 5
        set_vec( 9, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000);
        set_vec(10, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b1, 1'b0, 16'h0000); // reset
        set_vec(11, 1'b0, 1'b1, 23'h7FFFFF, 1'b1, 1'b1, 1'b0, 16'h0000); // 0 -> 23
        set_vec(12, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, 16'hFFFF); // 23 -> 7
        set_vec(13, 1'b1, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000); // reset with fill 7
        set_vec(14, 1'b0, 1'b1, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000); // 0 -> 23
        set_vec(15, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, 16'h0000); // old ones discarded
        set_vec(16, 1'b1, 1'b0, 23'h000000, 1'b0, 1'b1, 1'b0, 16'h0000); // reset
        set_vec(17, 1'b0, 1'b1, 23'h5A5A5A, 1'b0, 1'b1, 1'b0, 16'h0000); // 0 -> 23, sink stalled
        set_vec(18, 1'b0, 1'b1, 23'h5A5A5A, 1'b0, 1'b0, 1'b1, 16'hB4B4); // full, held
        set_vec(19, 1'b0, 1'b1, 23'h5A5A5A, 1'b0, 1'b0, 1'b1, 16'hB4B4);
        set_vec(20, 1'b0, 1'b0, 23'h000000, 1'b0, 1'b0, 1'b1, 16'hB4B4);
        set_vec(21, 1'b0, 1'b1, 23'h123456, 1'b1, 1'b1, 1'b1, 16'hB4B4); // out+in: 23 -> 30
        set_vec(22, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b1, 16'hB448); // 30 -> 14
        set_vec(23, 1'b0, 1'b0, 23'h000000, 1'b1, 1'b1, 1'b0, 16'h0000);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vt[i].r;
            valid_src = vt[i].vs;
            data_in   = vt[i].d;
            rdy_sink  = vt[i].rs;
            #1;
            check($sformatf("vec%0d rdy_src", i), 32'(rdy_src), 32'(vt[i].e_rdy));
            check($sformatf("vec%0d valid_sink", i), 32'(valid_sink), 32'(vt[i].e_vld));
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vt[i].e_dat));
        end

        // 16 incrementing words, source and sink always willing.
        begin
            int sent = 0;
            int nout = 0;
            int low  = 0;
            int cyc  = 0;
            logic ok;
            do_reset();
            exp_q.delete();
            for (int w = 1; w <= 16; w++) push_word(23'(w));
            while (nout < 23 && cyc < 60) begin
                @(negedge clk);
                valid_src = (sent < 16);
                data_in   = 23'(sent + 1);
                rdy_sink  = 1'b1;
                #1;
                if (!rdy_src) low++;
                if (valid_sink) begin
                    pop_word(exp_w, ok);
                    check($sformatf("stream word %0d", nout), {15'd0, ok, data_out}, {15'd0, 1'b1, exp_w});
                    nout++;
                end
                if (valid_src && rdy_src) sent++;
                cyc++;
            end
            @(negedge clk);
            valid_src = 1'b0;
            #1;
            check("stream output count", 32'(nout), 32'd23);
            check("stream words accepted", 32'(sent), 32'd16);
            check("stream rdy_src low cycles", 32'(low), 32'd7);
            check("stream drained fill", 32'(dut.fill), 32'd0);
            check("stream drained valid_sink", 32'(valid_sink), 32'd0);
            check("stream drained rdy_src", 32'(rdy_src), 32'd1);
        end

        // Random valid gaps and sink stalls against a bit-queue reference.
        begin
            int sent = 0;
            int nout = 0;
            int cyc  = 0;
            int max_fill = 0;
            logic prev_stall = 1'b0;
            logic [15:0] prev_dat = '0;
            logic ok;
            do_reset();
            exp_q.delete();
            while (!(sent == 1600 && exp_q.size() == 0) && cyc < 30000) begin
                @(negedge clk);
                valid_src = (sent < 1600) && ($urandom_range(0, 3) != 0);
                data_in   = 23'($urandom);
                rdy_sink  = 1'($urandom_range(0, 1));
                #1;
                if (prev_stall) begin
                    check("stall valid held", 32'(valid_sink), 32'd1);
                    check("stall data held", 32'(data_out), 32'(prev_dat));
                end
                if (valid_sink && rdy_sink) begin
                    pop_word(exp_w, ok);
                    check($sformatf("random word %0d", nout), {15'd0, ok, data_out}, {15'd0, 1'b1, exp_w});
                    nout++;
                end
                if (valid_src && rdy_src) begin
                    push_word(data_in);
                    sent++;
                end
                if (int'(dut.fill) > max_fill) max_fill = int'(dut.fill);
                prev_stall = valid_sink && !rdy_sink;
                prev_dat   = data_out;
                cyc++;
            end
            valid_src = 1'b0;
            check("random words accepted", 32'(sent), 32'd1600);
            check("random output count", 32'(nout), 32'd2300);
            check("random residual bits", 32'(exp_q.size()), 32'd0);
            check("random fill bound", 32'(max_fill <= 38), 32'd1);
        end

`ifdef DATA_SPLIT_LAST_EN
        // Single word with last: flushed as FFFF then zero-padded FE00.
        begin
            do_reset();
            @(negedge clk);
            valid_src = 1'b1; data_in = 23'h7FFFFF; last_src = 1'b1; rdy_sink = 1'b1;
            #1;
            check("last accept rdy_src", 32'(rdy_src), 32'd1);
            @(negedge clk);
            valid_src = 1'b0; last_src = 1'b0;
            #1;
            check("last w0 rdy_src", 32'(rdy_src), 32'd0);
            check("last w0 valid", 32'(valid_sink), 32'd1);
            check("last w0 data", 32'(data_out), 32'hFFFF);
            check("last w0 last_sink", 32'(last_sink), 32'd0);
            @(negedge clk);
            #1;
            check("last w1 rdy_src", 32'(rdy_src), 32'd0);
            check("last w1 valid", 32'(valid_sink), 32'd1);
            check("last w1 data", 32'(data_out), 32'hFE00);
            check("last w1 last_sink", 32'(last_sink), 32'd1);
            @(negedge clk);
            #1;
            check("last done rdy_src", 32'(rdy_src), 32'd1);
            check("last done valid", 32'(valid_sink), 32'd0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_split.md
Name: data_split

Overview:
- Width-reducing gearbox. Accepts IN_W-bit words on a valid/ready source port and emits OUT_W-bit words on a valid/ready sink port.
- Bit stream is MSB-first and contiguous across word boundaries. Default 23->16: every 16 input words yield exactly 23 output words.
- Sits on the egress side of the datapath, restoring 16-bit traffic from packed 23-bit words.

Parameters:
- IN_W, 23, input word width; must satisfy IN_W >= OUT_W.
- OUT_W, 16, output word width; must satisfy OUT_W >= 1.
- BUF_W (localparam), IN_W+OUT_W-1, bit-buffer width.
- FILL_W (localparam), $clog2(BUF_W+1), fill-counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  IN_W  source word; bit IN_W-1 is first in stream order.
- valid_src  input  1  source word valid.
- rdy_src  output  1  block can accept a source word.
- data_out  output  OUT_W  sink word; bit OUT_W-1 is first in stream order.
- valid_sink  output  1  sink word valid.
- rdy_sink  input  1  sink ready.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- State:
  - buf[BUF_W-1:0]: valid bits left-justified; buf[BUF_W-1] is the oldest bit.
  - fill: number of valid bits, range 0..BUF_W.
- Reset (async, any time, including mid-word): buf=0, fill=0, rdy_src=1, valid_sink=0, data_out=0. Partial bits are discarded; no output until new input.
- Handshakes:
  - in_fire = valid_src & rdy_src.
  - out_fire = valid_sink & rdy_sink.
- Sink side:
  - valid_sink = (fill >= OUT_W).
  - data_out = buf[BUF_W-1 -: OUT_W]; all zero when fill < OUT_W.
  - No combinational path from data_in or valid_src to the sink outputs.
- Source side:
  - rdy_src = (fill <= BUF_W-IN_W) | (out_fire & (fill-OUT_W <= BUF_W-IN_W)).
  - This combinational path from rdy_sink to rdy_src is intentional; it sustains one output per cycle.
- Update per cycle, with f' = fill - (out_fire ? OUT_W : 0):
  - If out_fire: buf shifts left by OUT_W, zero-filled.
  - If in_fire: data_in is written at bit positions [BUF_W-1-f' -: IN_W] of the shifted buffer.
  - fill <= f' + (in_fire ? IN_W : 0).
  - Bits below fill are don't-care internally but kept zero.
- Simultaneous in_fire and out_fire in the same cycle is legal; the shift happens first, then the append.
- Stall: while valid_sink=1 and rdy_sink=0, data_out is held stable. An accepted input only appends below the held bits.
- Latency: the first output is valid the cycle after the first accepted input, because IN_W >= OUT_W.
- Throughput: with the sink always ready, one output per cycle. rdy_src deasserts in (IN_W-OUT_W)/IN_W of cycles; at defaults, 7 of every 23 cycles.
- Boundaries:
  - fill never exceeds BUF_W.
  - fill=0 means empty and rdy_src=1.
  - No internal word counter wraps; stream alignment is implied purely by fill.
- valid_src may drop without handshake; data_in is not sampled unless in_fire.

Optional Feature:
- Macro: DATA_SPLIT_LAST_EN.
- When defined, add port last_src (input, 1) and port last_sink (output, 1).
- Input side, when last_src is accepted with in_fire:
  - A flush flag is set.
  - While flush is set, rdy_src=0.
  - The residual fill is zero-padded up to the next OUT_W multiple: valid_sink=1 whenever fill>0.
- Output side:
  - last_sink=1 on the output word that drains fill to 0.
  - The flush flag clears on that out_fire.
- Reset clears the flush flag.
- When undefined: ports are absent, partial bits wait for further input, and behaviour is exactly as above.

Test Plan:
- Reset then idle -> rdy_src=1, valid_sink=0, data_out=16'h0000. Assert rst mid-stream with fill=7 -> fill=0, valid_sink=0 on the next cycle.
- Input 23'h7FFFFF then 23'h000000, sink ready -> outputs 16'hFFFF, 16'hFE00, then 16'h0000 only once fill>=16. Remaining 14 zero bits wait for more input.
- 16 incrementing words 23'h000001..23'h000010 with continuous valid and ready -> exactly 23 outputs whose concatenation equals the input concatenation. fill=0 afterward; rdy_src low on exactly 7 cycles per 23.
- Random rdy_sink stalls (~50%) and random valid_src gaps over 1600 input words -> data_out is stable during every stall and the output bit stream matches the reference model bit-exactly. No overflow; fill stays <= 38.
- Sink held not-ready from reset while sending 23'h5A5A5A -> rdy_src=1 for the first word, 0 afterward once fill=23>15; valid_sink stays 1, data_out=16'hB4B4 held.
- DATA_SPLIT_LAST_EN: single word 23'h7FFFFF with last_src=1 -> outputs 16'hFFFF (last_sink=0), then 16'hFE00 (last_sink=1). rdy_src=0 until the flush completes, then returns to 1.
